// File: rtl/axi_lite_reg_bank.sv
// Register bank behind the AXI-Lite slave: ID/CTRL/STATUS/SCRATCH/IRQ registers
// served over level-request / pulse-ack RF ports with configurable wait states.
module axi_lite_reg_bank #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    ACK_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA11E_0001,
  parameter logic [31:0]           CTRL_RST    = 32'h0000_0000
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  RF_WREQ,
  input  logic [ADDR_WIDTH-1:0] RF_WADDR,
  input  logic [DATA_WIDTH-1:0] RF_WDATA,
  output logic                  RF_WACK,
  output logic                  RF_WERROR,
  input  logic                  RF_RREQ,
  input  logic [ADDR_WIDTH-1:0] RF_RADDR,
  output logic                  RF_RACK,
  output logic [DATA_WIDTH-1:0] RF_RDATA,
  output logic                  RF_RERROR,
  output logic [31:0]           CTRL_OUT,
  input  logic [31:0]           STATUS_IN,
  input  logic [31:0]           IRQ_SET,
  output logic                  IRQ
);

  localparam int CW = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, ACK, HOLD} state_e;

  state_e                state_q, state_d;
  logic                  isWr_q, isWr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           ctrl_q, irqStat_q, irqStat_d, irqEn_q;
  logic [DATA_WIDTH-1:0] scratch_q, rdata_q, rdVal, w1cMask;
  logic                  werr_q, rerr_q, irq_q;
  logic [ADDR_WIDTH-1:0] wOff, rOff;
  logic                  wErr, rdErr, wrAck, rdAck;

  // Offsets wrap below BASE_ADDR, so a single unsigned compare rejects both sides of the window.
  assign wOff  = RF_WADDR - BASE_ADDR;
  assign rOff  = RF_RADDR - BASE_ADDR;
  assign wErr  = (RF_WADDR[1:0] != 2'b00) || (wOff >= ADDR_WIDTH'(24)) ||
                 (wOff[4:2] == 3'd0) || (wOff[4:2] == 3'd2);
  assign rdErr = (RF_RADDR[1:0] != 2'b00) || (rOff >= ADDR_WIDTH'(24));

  assign wrAck = (state_q == ACK) && isWr_q;
  assign rdAck = (state_q == ACK) && !isWr_q;

  always_comb begin
    rdVal = '0;
    if (!rdErr) begin
      case (rOff[4:2])
        3'd0:    rdVal = ID_VALUE;
        3'd1:    rdVal = ctrl_q;
        3'd2:    rdVal = STATUS_IN;
        3'd3:    rdVal = scratch_q;
        3'd4:    rdVal = irqStat_q;
        3'd5:    rdVal = irqEn_q;
        default: rdVal = '0;
      endcase
    end
  end

  // Set pulses are OR-ed in after the clear so a simultaneous set survives.
  always_comb begin
    w1cMask   = (wrAck && !wErr && wOff[4:2] == 3'd4) ? RF_WDATA : '0;
    irqStat_d = (irqStat_q & ~w1cMask) | IRQ_SET;
  end

  always_comb begin
    state_d = state_q;
    isWr_d  = isWr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (RF_WREQ) begin
          isWr_d  = 1'b1;
          state_d = (ACK_LATENCY == 1) ? ACK : WR_WAIT;
        end else if (RF_RREQ) begin
          isWr_d  = 1'b0;
          state_d = (ACK_LATENCY == 1) ? ACK : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (cnt_q == CW'(ACK_LATENCY - 2)) state_d = ACK;
        else cnt_d = cnt_q + 1'b1;
      end
      ACK:  state_d = HOLD;
      HOLD: if (isWr_q ? !RF_WREQ : !RF_RREQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      isWr_q    <= 1'b0;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_RST;
      scratch_q <= '0;
      irqStat_q <= '0;
      irqEn_q   <= '0;
      rdata_q   <= '0;
      werr_q    <= 1'b0;
      rerr_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      isWr_q    <= isWr_d;
      cnt_q     <= cnt_d;
      irqStat_q <= irqStat_d;
      irq_q     <= |(irqStat_q & irqEn_q);
      if (wrAck) begin
        werr_q <= wErr;
        if (!wErr) begin
          case (wOff[4:2])
            3'd1:    ctrl_q    <= RF_WDATA;
            3'd3:    scratch_q <= RF_WDATA;
            3'd5:    irqEn_q   <= RF_WDATA;
            default: ;
          endcase
        end
      end
      if (rdAck) begin
        rdata_q <= rdVal;
        rerr_q  <= rdErr;
      end
    end
  end

  // Ack-cycle results are shown immediately and held in the _q copies afterwards.
  assign RF_WACK   = wrAck;
  assign RF_RACK   = rdAck;
  assign RF_WERROR = wrAck ? wErr : werr_q;
  assign RF_RDATA  = rdAck ? rdVal : rdata_q;
  assign RF_RERROR = rdAck ? rdErr : rerr_q;
  assign CTRL_OUT  = ctrl_q;
  assign IRQ       = irq_q;

endmodule
